rsa_modexp_core: RTL and testbench

RSA_MODEXP_CORE -- requirements
Module: rsa_modexp_core

---
 rtl/rsa_modexp_core.sv | 189 ++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// ----------------------------------------------------------------------------
// rsa_modexp_core
//
// Purpose: modular exponentiation o_a_pow_d = i_a^i_d mod i_n for an odd
// modulus, using LSB-first square-and-multiply with bit-serial Montgomery
// products (R = 2^WIDTH).
//
// The base is first brought into Montgomery form (t = a*R mod n) while the
// running product m starts at plain 1. Mont(m, t) = m*t*R^-1 therefore keeps
// m in plain form and Mont(t, t) keeps t in Montgomery form, so no final
// conversion out of the Montgomery domain is needed.
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_start     start request, sampled only in IDLE
//   i_a         base (must be < i_n)
//   i_d         exponent
//   i_n         modulus (must be odd and > 1)
//   o_a_pow_d   result, held from one DONE to the next
//   o_finished  one-cycle completion pulse
//   o_busy      high whenever the FSM is not in IDLE
//
// Configuration macro: RSA_MODEXP_EARLY_EXIT_EN
//   defined   : LOOP stops after the highest set bit of d (d = 0 skips LOOP)
//   undefined : all WIDTH iterations always run (constant time)
// ----------------------------------------------------------------------------
module rsa_modexp_core #(
   parameter int WIDTH = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_d,
   input  logic [WIDTH-1:0] i_n,
   output logic [WIDTH-1:0] o_a_pow_d,
   output logic             o_finished,
   output logic             o_busy
);

   localparam int CW = $clog2(WIDTH + 1) + 1;
   // Two spare bits: acc < 2n and acc + y + n < 4n never overflow.
   localparam int AW = WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_LOOP, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_d, r_n, r_m, r_t;
   logic [WIDTH-1:0] r_xm, r_xt;        // multiplier bits, consumed LSB first
   logic [AW-1:0]    r_acc_m, r_acc_t;
   logic [CW-1:0]    r_cnt, r_iter;
   logic [WIDTH-1:0] r_result;
   logic             r_finished;

   logic             w_cnt_last, w_iter_last, w_loop_end, w_prep_skip;
   logic [AW-1:0]    w_prep_src;
   logic [WIDTH-1:0] w_t_prep, w_m_mont, w_t_mont, w_m_new;

   // One add/halve step of a bit-serial Montgomery product.
   function automatic logic [AW-1:0] mont_step(input logic [AW-1:0]    acc,
                                               input logic             xb,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] n);
      logic [AW-1:0] s;
      s = acc + (xb ? AW'(y) : '0);
      if (s[0]) s = s + AW'(n);
      return s >> 1;
   endfunction

   // Final conditional subtract; for legal operands the input is < 2n.
   function automatic logic [WIDTH-1:0] cond_sub(input logic [AW-1:0]    v,
                                                 input logic [WIDTH-1:0] n);
      logic [AW-1:0] r;
      r = (v >= AW'(n)) ? v - AW'(n) : v;
      return r[WIDTH-1:0];
   endfunction

   assign w_cnt_last  = (r_cnt == CW'(WIDTH));
   assign w_iter_last = (r_iter == CW'(WIDTH - 1));

`ifdef RSA_MODEXP_EARLY_EXIT_EN
   // r_d is shifted right once per iteration, so r_d[0] is the current bit.
   assign w_loop_end  = w_iter_last || (r_d[WIDTH-1:1] == '0);
   assign w_prep_skip = (r_d == '0);
`else
   assign w_loop_end  = w_iter_last;
   assign w_prep_skip = 1'b0;
`endif

   // PREP step 0 reduces a once; steps 1..WIDTH double modulo n.
   assign w_prep_src = (r_cnt == '0) ? AW'(r_t) : AW'({r_t, 1'b0});
   assign w_t_prep   = cond_sub(w_prep_src, r_n);

   assign w_m_mont = cond_sub(r_acc_m, r_n);
   assign w_t_mont = cond_sub(r_acc_t, r_n);
   assign w_m_new  = r_d[0] ? w_m_mont : r_m;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_PREP;
         S_PREP:  if (w_cnt_last) w_state_nxt = w_prep_skip ? S_DONE : S_LOOP;
         S_LOOP:  if (w_cnt_last && w_loop_end) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_busy     = (r_state != S_IDLE);
   assign o_finished = r_finished;
   assign o_a_pow_d  = r_result;

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_d        <= '0;
         r_n        <= '0;
         r_m        <= '0;
         r_t        <= '0;
         r_xm       <= '0;
         r_xt       <= '0;
         r_acc_m    <= '0;
         r_acc_t    <= '0;
         r_cnt      <= '0;
         r_iter     <= '0;
         r_result   <= '0;
         r_finished <= 1'b0;
      end else begin
         r_finished <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_t     <= i_a;
                  r_d     <= i_d;
                  r_n     <= i_n;
                  r_cnt   <= '0;
                  r_iter  <= '0;
                  r_acc_m <= '0;
                  r_acc_t <= '0;
               end
            end
            S_PREP: begin
               r_t <= w_t_prep;
               if (w_cnt_last) begin
                  r_cnt <= '0;
                  r_m   <= WIDTH'(1);
                  r_xm  <= WIDTH'(1);
                  r_xt  <= w_t_prep;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_LOOP: begin
               if (!w_cnt_last) begin
                  // Both products share y = t and run side by side.
                  r_acc_m <= mont_step(r_acc_m, r_xm[0], r_t, r_n);
                  r_acc_t <= mont_step(r_acc_t, r_xt[0], r_t, r_n);
                  r_xm    <= r_xm >> 1;
                  r_xt    <= r_xt >> 1;
                  r_cnt   <= r_cnt + CW'(1);
               end else begin
                  r_m     <= w_m_new;
                  r_t     <= w_t_mont;
                  r_xm    <= w_m_new;
                  r_xt    <= w_t_mont;
                  r_acc_m <= '0;
                  r_acc_t <= '0;
                  r_cnt   <= '0;
                  r_iter  <= r_iter + CW'(1);
                  r_d     <= r_d >> 1;
               end
            end
            S_DONE: begin
               r_result   <= r_m;
               r_finished <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// ----------------------------------------------------------------------------
// tb_rsa_modexp_core
//
// Directed bench for rsa_modexp_core: an 8-bit instance for the small
// hand-computed vectors, reset/abort and start-handling cases, and a 256-bit
// instance for a large Fermat vector (a^p mod p = a, p = 2^255 - 19).
// Latency expectations follow RSA_MODEXP_EARLY_EXIT_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_rsa_modexp_core;

   logic         clk = 1'b0;
   logic         rst;
   logic         st8, st256;
   logic [7:0]   a8, d8, n8, res8;
   logic         fin8, b8;
   logic [255:0] a256, d256, n256, res256;
   logic         fin256, b256;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rsa_modexp_core #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(st8),
      .i_a(a8), .i_d(d8), .i_n(n8),
      .o_a_pow_d(res8), .o_finished(fin8), .o_busy(b8));

   rsa_modexp_core #(.WIDTH(256)) dut256 (
      .i_clk(clk), .i_rst(rst), .i_start(st256),
      .i_a(a256), .i_d(d256), .i_n(n256),
      .o_a_pow_d(res256), .o_finished(fin256), .o_busy(b256));

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected latency for the 8-bit instance (accept edge to finish edge).
   function automatic int exp_lat8(input logic [7:0] d);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
      int h;
      h = -1;
      for (int i = 0; i < 8; i++) if (d[i]) h = i;
      if (h < 0) return 10;
      return 9 + (h + 1) * 9 + 1;
`else
      return 82;
`endif
   endfunction

   task automatic wait_done(input bit big, input int limit,
                            output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < limit) begin
         @(posedge clk); #1;
         lat++;
         ok = big ? fin256 : fin8;
      end
      if (!ok) begin
         checks++;
         errors++;
         $error("FAIL finish_timeout: observed no o_finished after %0d cycles, required a finish", lat);
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] n, input logic [7:0] exp);
      int lat;
      bit ok;
      a8 = a; d8 = d; n8 = n; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      check({tag, "_busy"}, 256'(b8), 256'(1));
      wait_done(1'b0, 200, lat, ok);
      if (ok) begin
         check({tag, "_res"},  256'(res8), 256'(exp));
         check({tag, "_lat"},  256'(lat),  256'(exp_lat8(d)));
         check({tag, "_idle"}, 256'(b8),   256'(0));
      end
   endtask

   initial begin
      int lat, lat2;
      bit ok;
      logic [255:0] p, base;

      rst = 1'b1; st8 = 1'b0; st256 = 1'b0;
      a8 = '0; d8 = '0; n8 = '0;
      a256 = '0; d256 = '0; n256 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_res",  256'(res8), 256'(0));
      check("rst_fin",  256'(fin8), 256'(0));
      check("rst_busy", 256'(b8),   256'(0));
      rst = 1'b0;

      // basic vectors
      run8("v5_3_11",  8'd5,   8'd3,   8'd11,  8'd4);
      run8("v7_13_11", 8'd7,   8'd13,  8'd11,  8'd2);
      run8("d0",       8'd7,   8'd0,   8'd11,  8'd1);
      run8("d1",       8'd9,   8'd1,   8'd11,  8'd9);
      run8("dmax",     8'd3,   8'd255, 8'd11,  8'd1);   // 3^5 = 1 mod 11
      run8("nmax",     8'd254, 8'd3,   8'd255, 8'd254); // (-1)^3 mod 255

      // completion pulse lasts exactly one cycle; result holds
      @(posedge clk); #1;
      check("pulse_width", 256'(fin8), 256'(0));
      check("res_hold",    256'(res8), 256'(254));

      // start while busy is ignored
      a8 = 8'd5; d8 = 8'd3; n8 = 8'd11; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      a8 = 8'd7; d8 = 8'd13; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      wait_done(1'b0, 200, lat, ok);
      if (ok) begin
         check("busy_start_res", 256'(res8),     256'(4));
         check("busy_start_lat", 256'(21 + lat), 256'(exp_lat8(8'd3)));
      end

      // start held high: back-to-back operations
      a8 = 8'd2; d8 = 8'd10; n8 = 8'd13; st8 = 1'b1;        // 1024 mod 13 = 10
      @(posedge clk); #1;
      wait_done(1'b0, 200, lat, ok);
      if (ok) begin
         check("held_res1", 256'(res8), 256'(10));
         check("held_lat1", 256'(lat),  256'(exp_lat8(8'd10)));
      end
      @(posedge clk); #1;
      st8 = 1'b0;
      check("held_restart_busy", 256'(b8),   256'(1));
      check("held_fin_low",      256'(fin8), 256'(0));
      check("held_res_kept",     256'(res8), 256'(10));
      wait_done(1'b0, 200, lat, ok);
      if (ok) begin
         check("held_res2", 256'(res8), 256'(10));
         check("held_lat2", 256'(lat),  256'(exp_lat8(8'd10)));
      end

      // reset 30 cycles into LOOP aborts without a finish pulse
      a8 = 8'd7; d8 = 8'd13; n8 = 8'd11; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      lat2 = 0;
      repeat (39) begin
         @(posedge clk); #1;
         if (fin8) lat2++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_no_fin_before", 256'(lat2), 256'(0));
      check("abort_fin",  256'(fin8), 256'(0));
      check("abort_res",  256'(res8), 256'(0));
      check("abort_busy", 256'(b8),   256'(0));
      rst = 1'b0;
      run8("after_abort", 8'd5, 8'd3, 8'd11, 8'd4);

      // 256-bit: a^p mod p = a for prime p = 2^255 - 19; mid-run start ignored
      p    = (256'd1 << 255) - 256'd19;
      base = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
      a256 = base; d256 = p; n256 = p; st256 = 1'b1;
      @(posedge clk); #1;
      st256 = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      a256 = 256'd5; d256 = 256'd2; st256 = 1'b1;
      @(posedge clk); #1;
      st256 = 1'b0;
      check("w256_busy", 256'(b256), 256'(1));
      wait_done(1'b1, 70000, lat, ok);
      if (ok) begin
         check("w256_res", res256, base);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
         check("w256_lat", 256'(1001 + lat), 256'(257 + 255 * 257 + 1));
`else
         check("w256_lat", 256'(1001 + lat), 256'(257 + 256 * 257 + 1));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
